xsleena_rom_loader: RTL and testbench

- Writer side of the per-ROM load port that every ROM-backed dual-port block exposes (bram_wr, bram_data, bram_addr, bram_cs).
- Consumes the MiSTer HPS ioctl download byte stream and decodes each byte's linear address into one of 8 ROM regions.
- Drives a shared write bus with one-hot chip selects, a fixed-length write pulse and ioctl_wait back-pressure.
- Sits in the top-level core between hps_io and the video/CPU ROM blocks; also reports load completion and a checksum.

---
 rtl/xsleena_rom_loader.sv | 174 +++++++++++++++++
 tb/tb_xsleena_rom_loader.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xsleena_rom_loader.sv
// xsleena_rom_loader: HPS ioctl byte stream to the shared ROM write bus.
// Decodes 8 regions, pulses bram_wr, tracks byte count and checksum.
`timescale 1ns/1ps
module xsleena_rom_loader #(
  parameter logic [7:0]   ROM_INDEX   = 8'd0,
  parameter logic [159:0] REGION_BASE = {8{20'h0}},
  parameter logic [24:0]  LOAD_END    = 25'h1FFFFF,
  parameter int           HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        bram_wr,
  output logic [7:0]  bram_data,
  output logic [19:0] bram_addr,
  output logic [7:0]  bram_cs,
  output logic        rom_loaded,
  output logic [24:0] byte_count,
  output logic [15:0] checksum,
  output logic [1:0]  error_flags
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DECODE,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [24:0] addr_q;
  logic [7:0]  data_q;
  logic [2:0]  hold_cnt;
  logic        abort_q;
  logic [2:0]  region;
  logic [19:0] base_sel;
  logic [19:0] offset;
  logic        in_range;
  logic        last_beat;
  logic        abort_now;

  assign offset    = addr_q[19:0] - base_sel;
  assign in_range  = addr_q <= LOAD_END;
  assign last_beat = hold_cnt == 3'(HOLD_CYCLES - 1);
  assign abort_now = abort_q | ~ioctl_download;

  // Region lookup: highest region whose base is at or below the address.
  always_comb begin
    region   = 3'd0;
    base_sel = 20'h0;
    for (int r = 0; r < 8; r++) begin
      if ({5'h0, REGION_BASE[r*20 +: 20]} <= addr_q) begin
        region   = 3'(r);
        base_sel = REGION_BASE[r*20 +: 20];
      end
    end
  end

  // Next-state logic; a lost download ends the current byte in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ioctl_download && ioctl_index == ROM_INDEX)
          state_nxt = ARMED;
      end
      ARMED: begin
        if (ioctl_wr)
          state_nxt = DECODE;
        else if (!ioctl_download)
          state_nxt = DONE;
      end
      DECODE: begin
        if (in_range)
          state_nxt = WRITE;
        else
          state_nxt = abort_now ? DONE : ARMED;
      end
      WRITE: begin
        if (last_beat)
          state_nxt = abort_now ? DONE : ARMED;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the registered write bus and load statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      hold_cnt    <= '0;
      abort_q     <= 1'b0;
      ioctl_wait  <= 1'b0;
      bram_wr     <= 1'b0;
      bram_data   <= '0;
      bram_addr   <= '0;
      bram_cs     <= '0;
      rom_loaded  <= 1'b0;
      byte_count  <= '0;
      checksum    <= '0;
      error_flags <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (state_nxt == ARMED) begin
            byte_count  <= '0;
            checksum    <= '0;
            error_flags <= '0;
            rom_loaded  <= 1'b0;
            abort_q     <= 1'b0;
          end
        end
        ARMED: begin
          if (ioctl_wr) begin
            addr_q     <= ioctl_addr;
            data_q     <= ioctl_dout;
            ioctl_wait <= 1'b1;
          end
        end
        DECODE: begin
          if (ioctl_wr)
            error_flags[1] <= 1'b1;
          if (!ioctl_download)
            abort_q <= 1'b1;
          if (in_range) begin
            bram_wr   <= 1'b1;
            bram_cs   <= 8'd1 << region;
            bram_addr <= offset;
            bram_data <= data_q;
            hold_cnt  <= '0;
          end else begin
            error_flags[0] <= 1'b1;
            ioctl_wait     <= 1'b0;
            abort_q        <= 1'b0;
          end
        end
        WRITE: begin
          if (ioctl_wr)
            error_flags[1] <= 1'b1;
          if (!ioctl_download)
            abort_q <= 1'b1;
          if (last_beat) begin
            bram_wr    <= 1'b0;
            bram_cs    <= '0;
            ioctl_wait <= 1'b0;
            abort_q    <= 1'b0;
            checksum   <= checksum + {8'h0, data_q};
            if (byte_count != '1)
              byte_count <= byte_count + 25'd1;
          end else begin
            hold_cnt <= hold_cnt + 3'd1;
          end
        end
        DONE: begin
          if (byte_count != '0)
            rom_loaded <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xsleena_rom_loader.sv
// tb_xsleena_rom_loader: randomized bench with a region/checksum model.
// Bus activity is logged per write pulse and compared task by task.
`timescale 1ns/1ps
module tb_xsleena_rom_loader;

  localparam logic [24:0] LEND = 25'h17FFF;
  localparam int          HOLD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        bram_wr;
  logic [7:0]  bram_data;
  logic [19:0] bram_addr;
  logic [7:0]  bram_cs;
  logic        rom_loaded;
  logic [24:0] byte_count;
  logic [15:0] checksum;
  logic [1:0]  error_flags;

  xsleena_rom_loader #(
    .ROM_INDEX  (8'd0),
    .REGION_BASE({20'h38000, 20'h30000, 20'h28000, 20'h20000,
                  20'h18000, 20'h10000, 20'h08000, 20'h00000}),
    .LOAD_END   (LEND),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .bram_wr       (bram_wr),
    .bram_data     (bram_data),
    .bram_addr     (bram_addr),
    .bram_cs       (bram_cs),
    .rom_loaded    (rom_loaded),
    .byte_count    (byte_count),
    .checksum      (checksum),
    .error_flags   (error_flags)
  );

  always #5 clk = ~clk;

  int base_tab [8] = '{32'h0, 32'h8000, 32'h10000, 32'h18000,
                       32'h20000, 32'h28000, 32'h30000, 32'h38000};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_strobe = 0;
  int bad_cs = 0;
  int m_count = 0;
  int m_sum = 0;
  logic [1:0] m_flags = 2'b00;

  typedef struct {
    logic [7:0]  cs;
    logic [19:0] addr;
    logic [7:0]  data;
    int          len;
    int          start;
    bit          stable;
  } rec_t;

  rec_t wr_log[$];
  rec_t cur;
  bit   in_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Log each write pulse; start is the first edge that samples it high.
  always @(negedge clk) begin
    if ((bram_cs & (bram_cs - 8'd1)) != 8'd0) bad_cs++;
    if ((bram_cs != 8'd0) != bram_wr) bad_cs++;
    if (bram_wr) begin
      if (!in_pulse) begin
        cur.cs = bram_cs;
        cur.addr = bram_addr;
        cur.data = bram_data;
        cur.len = 1;
        cur.start = cyc + 1;
        cur.stable = 1'b1;
        in_pulse = 1'b1;
      end else begin
        cur.len++;
        if (bram_cs !== cur.cs || bram_addr !== cur.addr ||
            bram_data !== cur.data)
          cur.stable = 1'b0;
      end
    end else if (in_pulse) begin
      wr_log.push_back(cur);
      in_pulse = 1'b0;
    end
  end

  function automatic void model(input int a, output bit ok,
                                output logic [7:0] cs,
                                output logic [19:0] off);
    int r = 0;
    for (int i = 0; i < 8; i++)
      if (base_tab[i] <= a) r = i;
    ok = a <= int'(LEND);
    cs = 8'(1 << r);
    off = 20'(a - base_tab[r]);
  endfunction

  task automatic strobe(input int a, input int d);
    @(posedge clk); #1;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = 8'(d);
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    last_strobe = cyc;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (!ioctl_wait) break;
      n++;
    end
    #1;
  endtask

  task automatic send(input int a, input int d, output int w);
    strobe(a, d);
    wait_idle(w);
  endtask

  task automatic start_dl(input int idx);
    @(posedge clk); #1;
    ioctl_download = 1'b1;
    ioctl_index = 8'(idx);
    @(posedge clk); #1;
  endtask

  task automatic end_dl();
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bram_wr !== 1'b0 || bram_cs !== 8'h0 || ioctl_wait !== 1'b0)
      $display("FAIL reset_bus: wr=%b cs=%h wait=%b want 0 0 0",
               bram_wr, bram_cs, ioctl_wait);
    if (bram_wr !== 1'b0 || bram_cs !== 8'h0 || ioctl_wait !== 1'b0)
      errors++;
    checks++;
    if (byte_count !== 25'h0 || checksum !== 16'h0 ||
        rom_loaded !== 1'b0 || error_flags !== 2'b00 ||
        bram_addr !== 20'h0 || bram_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: cnt=%h sum=%h ld=%b err=%b a=%h d=%h want 0",
               byte_count, checksum, rom_loaded, error_flags,
               bram_addr, bram_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start_dl(0);
    strobe(32'h8003, 32'h5A);
    @(posedge clk); #1;
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk);
    checks++;
    if (bram_wr !== 1'b1) begin
      errors++;
      $display("FAIL reset_midwrite_active: wr=%b want 1", bram_wr);
    end
    @(negedge clk);
    checks++;
    if (bram_wr !== 1'b0 || bram_cs !== 8'h0 || ioctl_wait !== 1'b0 ||
        rom_loaded !== 1'b0 || error_flags !== 2'b00) begin
      errors++;
      $display("FAIL reset_midwrite: wr=%b cs=%h wait=%b ld=%b err=%b want 0",
               bram_wr, bram_cs, ioctl_wait, rom_loaded, error_flags);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    wr_log.delete();
  endtask

  task automatic test_single();
    int w;
    rec_t r;
    start_dl(0);
    send(32'h8003, 32'hA5, w);
    checks++;
    if (wr_log.size() != 1) begin
      errors++;
      $display("FAIL single_count: writes=%0d want 1", wr_log.size());
      wr_log.delete();
    end else begin
      r = wr_log.pop_front();
      if (r.cs !== 8'b0000_0010 || r.addr !== 20'h00003 ||
          r.data !== 8'hA5 || !r.stable) begin
        errors++;
        $display("FAIL single_bus: cs=%h a=%h d=%h st=%0d want 02 00003 a5 1",
                 r.cs, r.addr, r.data, r.stable);
      end
      checks++;
      if (r.start != last_strobe + 2 || r.len != HOLD) begin
        errors++;
        $display("FAIL single_timing: start=+%0d len=%0d want +2 %0d",
                 r.start - last_strobe, r.len, HOLD);
      end
    end
    checks++;
    if (w != HOLD + 1) begin
      errors++;
      $display("FAIL single_wait: wait_cycles=%0d want %0d", w, HOLD + 1);
    end
    checks++;
    if (byte_count !== 25'd1 || checksum !== 16'h00A5) begin
      errors++;
      $display("FAIL single_stats: cnt=%h sum=%h want 1 00a5",
               byte_count, checksum);
    end
    end_dl();
    checks++;
    if (rom_loaded !== 1'b1) begin
      errors++;
      $display("FAIL single_loaded: rom_loaded=%b want 1", rom_loaded);
    end
  endtask

  task automatic test_boundaries();
    int addrs [6] = '{32'h7FFF, 32'h8000, 32'hFFFF,
                      32'h10000, 32'h17FFF, 32'h0};
    int w, d;
    bit ok;
    logic [7:0] ecs;
    logic [19:0] eoff;
    rec_t r;
    start_dl(0);
    foreach (addrs[i]) begin
      d = $urandom_range(255, 0);
      send(addrs[i], d, w);
      model(addrs[i], ok, ecs, eoff);
      checks++;
      if (wr_log.size() != 1) begin
        errors++;
        $display("FAIL boundary_count @%h: writes=%0d want 1",
                 addrs[i], wr_log.size());
        wr_log.delete();
      end else begin
        r = wr_log.pop_front();
        if (r.cs !== ecs || r.addr !== eoff || r.data !== 8'(d) ||
            r.len != HOLD) begin
          errors++;
          $display("FAIL boundary @%h: cs=%h a=%h d=%h len=%0d want %h %h %h %0d",
                   addrs[i], r.cs, r.addr, r.data, r.len,
                   ecs, eoff, 8'(d), HOLD);
        end
      end
    end
    end_dl();
  endtask

  task automatic test_full_load();
    int w, a, d;
    bit ok;
    logic [7:0] ecs;
    logic [19:0] eoff;
    rec_t r;
    start_dl(0);
    checks++;
    if (rom_loaded !== 1'b0 || byte_count !== 25'h0) begin
      errors++;
      $display("FAIL load_clear: ld=%b cnt=%h want 0 0", rom_loaded, byte_count);
    end
    m_count = 0;
    m_sum = 0;
    bad_cs = 0;
    for (int i = 0; i < 2048; i++) begin
      a = (i < 1024) ? int'($urandom_range(32'h17FFF, 0)) : 32'hFE00 + i - 1024;
      d = $urandom_range(255, 0);
      send(a, d, w);
      model(a, ok, ecs, eoff);
      m_count++;
      m_sum = (m_sum + d) & 32'hFFFF;
      checks++;
      if (wr_log.size() != 1) begin
        errors++;
        $display("FAIL load_count @%h: writes=%0d want 1", a, wr_log.size());
        wr_log.delete();
      end else begin
        r = wr_log.pop_front();
        if (r.cs !== ecs || r.addr !== eoff || r.data !== 8'(d) ||
            r.len != HOLD || !r.stable || w != HOLD + 1) begin
          errors++;
          $display("FAIL load @%h: cs=%h a=%h d=%h len=%0d w=%0d want %h %h %h %0d %0d",
                   a, r.cs, r.addr, r.data, r.len, w,
                   ecs, eoff, 8'(d), HOLD, HOLD + 1);
        end
      end
    end
    checks++;
    if (byte_count !== 25'(m_count) || checksum !== 16'(m_sum) ||
        error_flags !== 2'b00) begin
      errors++;
      $display("FAIL load_stats: cnt=%h sum=%h err=%b want %h %h 0",
               byte_count, checksum, error_flags, m_count, m_sum);
    end
    checks++;
    if (bad_cs != 0) begin
      errors++;
      $display("FAIL load_onehot: violations=%0d want 0", bad_cs);
    end
    end_dl();
    checks++;
    if (rom_loaded !== 1'b1 || byte_count !== 25'(m_count) ||
        checksum !== 16'(m_sum)) begin
      errors++;
      $display("FAIL load_done: ld=%b cnt=%h sum=%h want 1 %h %h",
               rom_loaded, byte_count, checksum, m_count, m_sum);
    end
  endtask

  task automatic test_errors();
    int w, a, a1, d1;
    bit ok;
    logic [7:0] ecs;
    logic [19:0] eoff;
    rec_t r;
    start_dl(0);
    checks++;
    if (rom_loaded !== 1'b0 || error_flags !== 2'b00) begin
      errors++;
      $display("FAIL err_clear: ld=%b err=%b want 0 00", rom_loaded, error_flags);
    end
    send(32'h18000, 32'h3C, w);
    checks++;
    if (wr_log.size() != 0 || w != 1) begin
      errors++;
      $display("FAIL err_drop_18000: writes=%0d wait=%0d want 0 1",
               wr_log.size(), w);
      wr_log.delete();
    end
    checks++;
    if (error_flags !== 2'b01) begin
      errors++;
      $display("FAIL err_flag0: err=%b want 01", error_flags);
    end
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(32'h1FFFFFF, 32'h18001);
      send(a, $urandom_range(255, 0), w);
      checks++;
      if (wr_log.size() != 0 || w != 1) begin
        errors++;
        $display("FAIL err_drop @%h: writes=%0d wait=%0d want 0 1",
                 a, wr_log.size(), w);
        wr_log.delete();
      end
    end
    end_dl();
    checks++;
    if (byte_count !== 25'h0 || checksum !== 16'h0 || rom_loaded !== 1'b0) begin
      errors++;
      $display("FAIL err_empty_load: cnt=%h sum=%h ld=%b want 0 0 0",
               byte_count, checksum, rom_loaded);
    end
    for (int dly = 1; dly <= 2; dly++) begin
      start_dl(0);
      a1 = $urandom_range(32'h17FFF, 0);
      d1 = $urandom_range(255, 0);
      strobe(a1, d1);
      repeat (dly - 1) begin
        @(posedge clk); #1;
      end
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(a1 ^ 1);
      ioctl_dout = 8'(d1 ^ 32'hFF);
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      wait_idle(w);
      model(a1, ok, ecs, eoff);
      checks++;
      if (w >= 32 || error_flags !== 2'b10) begin
        errors++;
        $display("FAIL err_busy%0d: err=%b wait=%0d want 10 <32",
                 dly, error_flags, w);
      end
      checks++;
      if (wr_log.size() != 1) begin
        errors++;
        $display("FAIL err_busy%0d_count: writes=%0d want 1", dly, wr_log.size());
        wr_log.delete();
      end else begin
        r = wr_log.pop_front();
        if (r.cs !== ecs || r.addr !== eoff || r.data !== 8'(d1) ||
            r.len != HOLD || !r.stable) begin
          errors++;
          $display("FAIL err_busy%0d_bus: cs=%h a=%h d=%h want %h %h %h",
                   dly, r.cs, r.addr, r.data, ecs, eoff, 8'(d1));
        end
      end
      checks++;
      if (byte_count !== 25'd1 || checksum !== 16'(d1)) begin
        errors++;
        $display("FAIL err_busy%0d_stats: cnt=%h sum=%h want 1 %h",
                 dly, byte_count, checksum, d1);
      end
      end_dl();
      m_count = 1;
      m_sum = d1;
      m_flags = 2'b10;
    end
  endtask

  task automatic test_index_abort();
    int a, d;
    bit ok;
    logic [7:0] ecs;
    logic [19:0] eoff;
    rec_t r;
    start_dl(1);
    for (int i = 0; i < 4; i++) begin
      strobe($urandom_range(32'h17FFF, 0), $urandom_range(255, 0));
      checks++;
      if (ioctl_wait !== 1'b0) begin
        errors++;
        $display("FAIL index_wait: wait=%b want 0", ioctl_wait);
      end
    end
    end_dl();
    checks++;
    if (wr_log.size() != 0 || rom_loaded !== 1'b1 ||
        byte_count !== 25'(m_count) || checksum !== 16'(m_sum) ||
        error_flags !== m_flags) begin
      errors++;
      $display("FAIL index_ignore: wr=%0d ld=%b cnt=%h sum=%h err=%b want 0 1 %h %h %b",
               wr_log.size(), rom_loaded, byte_count, checksum, error_flags,
               m_count, m_sum, m_flags);
      wr_log.delete();
    end
    start_dl(0);
    a = $urandom_range(32'h17FFF, 0);
    d = $urandom_range(255, 0);
    strobe(a, d);
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bram_wr !== 1'b0 || byte_count !== 25'd1 || rom_loaded !== 1'b0) begin
      errors++;
      $display("FAIL abort_finish: wr=%b cnt=%h ld=%b want 0 1 0",
               bram_wr, byte_count, rom_loaded);
    end
    @(negedge clk);
    checks++;
    if (rom_loaded !== 1'b1) begin
      errors++;
      $display("FAIL abort_loaded: rom_loaded=%b want 1", rom_loaded);
    end
    #1;
    model(a, ok, ecs, eoff);
    checks++;
    if (wr_log.size() != 1) begin
      errors++;
      $display("FAIL abort_count: writes=%0d want 1", wr_log.size());
      wr_log.delete();
    end else begin
      r = wr_log.pop_front();
      if (r.cs !== ecs || r.addr !== eoff || r.data !== 8'(d) || r.len != HOLD) begin
        errors++;
        $display("FAIL abort_bus: cs=%h a=%h d=%h len=%0d want %h %h %h %0d",
                 r.cs, r.addr, r.data, r.len, ecs, eoff, 8'(d), HOLD);
      end
    end
    start_dl(0);
    end_dl();
    checks++;
    if (rom_loaded !== 1'b0 || byte_count !== 25'h0) begin
      errors++;
      $display("FAIL empty_reload: ld=%b cnt=%h want 0 0", rom_loaded, byte_count);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_full_load();
    test_errors();
    test_index_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
